// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - sample-rate sequencer driving the 8-bit R2R DAC code
// Ticks every div_reg+1 cycles and updates r2r_out from hold, FIFO, ramp or triangle source.
module dac_sample_scheduler #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic       wr_en,
  input  logic       load_divider,
  input  logic       clr_flags,
  output logic [7:0] r2r_out,
  output logic       sample_tick,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       underrun,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_FIFO = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_TRI  = 2'd3;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_dir_down;

  logic             w_fire;
  logic             w_fifo_mode;
  logic             w_empty_now;
  logic             w_full_now;
  logic             w_pop;
  logic             w_wr_req;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_unr_set;
  logic [CW-1:0]    w_count_nxt;
  logic [7:0]       w_r2r_nxt;
  logic             w_dir_nxt;

  // A divider load suppresses the fire so the new period starts cleanly from the load.
  assign w_fire      = enable && (r_cnt == '0) && !load_divider;
  assign w_fifo_mode = (mode == MODE_FIFO);
  assign w_empty_now = (r_count == '0);
  assign w_full_now  = (r_count == CW'(DEPTH));
  assign w_pop       = w_fire && w_fifo_mode && !w_empty_now;
  assign w_wr_req    = wr_en && !load_divider;
  assign w_push      = w_wr_req && (!w_full_now || w_pop);
  assign w_ovf_set   = w_wr_req && w_full_now && !w_pop;
  assign w_unr_set   = w_fire && w_fifo_mode && w_empty_now;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_comb begin
    w_r2r_nxt = r2r_out;
    w_dir_nxt = r_dir_down;
    case (mode)
      MODE_HOLD: w_r2r_nxt = r2r_out;
      MODE_FIFO: begin
        if (!w_empty_now) begin
          w_r2r_nxt = r_mem[r_rptr];
        end
      end
      MODE_RAMP: w_r2r_nxt = r2r_out + 8'd1;
      MODE_TRI: begin
        // Entering at an extreme with the wrong direction bounces instead of wrapping.
        if (!r_dir_down) begin
          if (r2r_out == 8'hFF) begin
            w_r2r_nxt = 8'hFE;
            w_dir_nxt = 1'b1;
          end else begin
            w_r2r_nxt = r2r_out + 8'd1;
            if (r2r_out == 8'hFE) begin
              w_dir_nxt = 1'b1;
            end
          end
        end else begin
          if (r2r_out == 8'h00) begin
            w_r2r_nxt = 8'h01;
            w_dir_nxt = 1'b0;
          end else begin
            w_r2r_nxt = r2r_out - 8'd1;
            if (r2r_out == 8'h01) begin
              w_dir_nxt = 1'b0;
            end
          end
        end
      end
      default: w_r2r_nxt = r2r_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div       <= '0;
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dir_down  <= 1'b0;
      r2r_out     <= 8'h00;
      sample_tick <= 1'b0;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (load_divider) begin
        r_div <= data[DIV_W-1:0];
        r_cnt <= data[DIV_W-1:0];
      end else if (!enable || w_fire) begin
        r_cnt <= r_div;
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end

      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      fifo_full  <= (w_count_nxt == CW'(DEPTH));
      fifo_empty <= (w_count_nxt == '0);

      sample_tick <= w_fire;
      if (w_fire) begin
        r2r_out    <= w_r2r_nxt;
        r_dir_down <= w_dir_nxt;
      end

      // A set event in the same cycle as clr_flags keeps the flag high.
      underrun <= w_unr_set || (underrun && !clr_flags);
      overflow <= w_ovf_set || (overflow && !clr_flags);
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - scoreboard bench for dac_sample_scheduler
// Driver steps a queue-based reference model each cycle; monitor compares DUT outputs.
module tb_dac_sample_scheduler;

  localparam int DEPTH = 16;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] data;
  logic       wr_en;
  logic       load_divider;
  logic       clr_flags;
  logic [7:0] r2r_out;
  logic       sample_tick;
  logic       fifo_full;
  logic       fifo_empty;
  logic       underrun;
  logic       overflow;

  dac_sample_scheduler #(.DEPTH(DEPTH), .DIV_W(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .mode         (mode),
    .data         (data),
    .wr_en        (wr_en),
    .load_divider (load_divider),
    .clr_flags    (clr_flags),
    .r2r_out      (r2r_out),
    .sample_tick  (sample_tick),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .underrun     (underrun),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       tick;
    bit [7:0] r2r;
    bit       full;
    bit       empty;
    bit       unr;
    bit       ovf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int       m_div;
  int       m_cnt;
  int       m_r2r;
  bit       m_down;
  bit       m_unr;
  bit       m_ovf;
  bit [7:0] m_fifo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div = 0;
    m_cnt = 0;
    m_r2r = 0;
    m_down = 1'b0;
    m_unr = 1'b0;
    m_ovf = 1'b0;
    m_fifo.delete();
  endtask

  task automatic model_step(input bit en, input bit [1:0] md, input bit [7:0] d,
                            input bit wr, input bit ld, input bit clr);
    bit   fire;
    bit   unr_ev;
    bit   ovf_ev;
    exp_t e;
    fire = en && (m_cnt == 0) && !ld;
    unr_ev = 1'b0;
    ovf_ev = 1'b0;
    if (fire) begin
      case (md)
        2'd1: begin
          if (m_fifo.size() > 0) m_r2r = m_fifo.pop_front();
          else unr_ev = 1'b1;
        end
        2'd2: m_r2r = (m_r2r + 1) % 256;
        2'd3: begin
          if (!m_down) begin
            if (m_r2r == 255) begin m_r2r = 254; m_down = 1'b1; end
            else begin m_r2r = m_r2r + 1; if (m_r2r == 255) m_down = 1'b1; end
          end else begin
            if (m_r2r == 0) begin m_r2r = 1; m_down = 1'b0; end
            else begin m_r2r = m_r2r - 1; if (m_r2r == 0) m_down = 1'b0; end
          end
        end
        default: ;
      endcase
    end
    if (wr && !ld) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else ovf_ev = 1'b1;
    end
    m_unr = unr_ev || (m_unr && !clr);
    m_ovf = ovf_ev || (m_ovf && !clr);
    if (ld) begin
      m_div = d;
      m_cnt = d;
    end else if (!en || fire) begin
      m_cnt = m_div;
    end else begin
      m_cnt = m_cnt - 1;
    end
    e.tick  = fire;
    e.r2r   = 8'(m_r2r);
    e.full  = (m_fifo.size() == DEPTH);
    e.empty = (m_fifo.size() == 0);
    e.unr   = m_unr;
    e.ovf   = m_ovf;
    sb.push_back(e);
  endtask

  task automatic drive(input bit en, input bit [1:0] md, input bit [7:0] d,
                       input bit wr, input bit ld, input bit clr);
    @(negedge clk);
    enable = en;
    mode = md;
    data = d;
    wr_en = wr;
    load_divider = ld;
    clr_flags = clr;
    model_step(en, md, d, wr, ld, clr);
  endtask

  task automatic run(input int n, input bit en, input bit [1:0] md);
    repeat (n) drive(en, md, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r2r"}, {24'd0, r2r_out}, 32'h00);
    chk({tag, "_tick"}, {31'd0, sample_tick}, 32'd0);
    chk({tag, "_empty"}, {31'd0, fifo_empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, fifo_full}, 32'd0);
    chk({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sample_tick", {31'd0, sample_tick}, {31'd0, e.tick});
        chk("r2r_out", {24'd0, r2r_out}, {24'd0, e.r2r});
        chk("fifo_full", {31'd0, fifo_full}, {31'd0, e.full});
        chk("fifo_empty", {31'd0, fifo_empty}, {31'd0, e.empty});
        chk("underrun", {31'd0, underrun}, {31'd0, e.unr});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  initial begin : driver
    bit [1:0] md;
    n_rst = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    data = 8'h00;
    wr_en = 1'b0;
    load_divider = 1'b0;
    clr_flags = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Ramp at full rate, including the 0xFF->0x00 wrap
    run(300, 1'b1, 2'd2);

    // HOLD with div=9, then reload mid-count
    drive(1'b1, 2'd0, 8'd9, 1'b0, 1'b1, 1'b0);
    run(35, 1'b1, 2'd0);
    drive(1'b1, 2'd0, 8'd9, 1'b0, 1'b1, 1'b0);
    run(25, 1'b1, 2'd0);

    // FIFO playback of three bytes, then underrun and clear
    drive(1'b0, 2'd0, 8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 8'h5A, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 8'h33, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 8'd3, 1'b0, 1'b1, 1'b0);
    run(20, 1'b1, 2'd1);
    drive(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 2'd1);

    // Fill past full, then drain
    drive(1'b0, 2'd1, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) drive(1'b0, 2'd1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    run(20, 1'b1, 2'd1);
    drive(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1);

    // Writes while full on pop cycles are accepted without overflow
    for (int i = 0; i < 16; i++) drive(1'b0, 2'd1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 2'd1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    run(25, 1'b1, 2'd1);

    // Asynchronous reset during playback with five entries queued
    drive(1'b0, 2'd1, 8'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 2'd1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    run(8, 1'b1, 2'd1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    enable = 1'b0;
    mode = 2'd0;
    wr_en = 1'b0;
    load_divider = 1'b0;
    clr_flags = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
    n_rst = 1'b1;
    run(2, 1'b1, 2'd1);

    // Full triangle period from 0x00
    drive(1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1);
    run(520, 1'b1, 2'd3);

    // Randomized traffic
    md = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      bit en;
      bit wr;
      bit ld;
      bit clr;
      bit [7:0] d;
      if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 9) != 0);
      wr  = ($urandom_range(0, 2) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      d   = ld ? 8'($urandom_range(0, 4)) : 8'($urandom);
      drive(en, md, d, wr, ld, clr);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sample-rate sequencer placed between the host-facing pins and the 8-bit R2R DAC code path.
- Generates a programmable sample tick from the system clock (10 MHz nominal).
- On each tick it updates the registered DAC code from one of four sources: hold, a host-filled sample FIFO, an internal ramp, or an internal triangle.
- Its r2r_out feeds the per-bit 1v8→3v3 level drivers unchanged.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DIV_W, 8, divider width; the divider value is loaded from data[DIV_W-1:0].

Ports:
- clk  input  1  system clock, 10 MHz nominal
- n_rst  input  1  asynchronous active-low reset
- enable  input  1  1 = tick generation runs; 0 = paused
- mode  input  2  0 HOLD, 1 FIFO, 2 RAMP, 3 TRIANGLE
- data  input  8  shared byte: FIFO write data or divider value
- wr_en  input  1  push data into FIFO (level; one push per cycle high)
- load_divider  input  1  load data into divider register (level)
- clr_flags  input  1  clear sticky underrun/overflow
- r2r_out  output  8  registered DAC code
- sample_tick  output  1  one-cycle pulse, coincident with each new r2r_out value
- fifo_full  output  1  count == DEPTH
- fifo_empty  output  1  count == 0
- underrun  output  1  sticky: tick in FIFO mode while empty
- overflow  output  1  sticky: write attempted while full and no pop

Behaviour:
- Reset (async, n_rst low), all outputs and state cleared:
  - r2r_out=0x00, sample_tick=0, fifo_empty=1, fifo_full=0, underrun=0, overflow=0.
  - div_reg=0, cnt=0, FIFO pointers/count=0, triangle direction=up.
- Reset release: takes effect on the first clk edge after n_rst rises. Reset mid-operation discards FIFO contents.
- Divider:
  - Internal fire = enable && cnt==0.
  - On fire: cnt<=div_reg. Otherwise, if enable: cnt<=cnt-1.
  - enable=0: cnt<=div_reg, no fire.
  - Tick period = div_reg+1 cycles; div_reg=0 gives a tick every cycle.
- load_divider:
  - div_reg<=data and cnt<=data in the same edge, overriding the decrement/fire for that cycle (no fire that cycle).
  - load_divider has priority over wr_en: the write that cycle is ignored and does not count as overflow.
- Output update: on a fire edge r2r_out takes its new value, and sample_tick is registered high for exactly the following cycle. A new value therefore appears one cycle after cnt reaches 0.
- Mode actions on fire (mode is sampled at the fire edge; switching modes never resets r2r_out):
  - HOLD: r2r_out unchanged; sample_tick still pulses.
  - FIFO, not empty: r2r_out<=head entry, pop.
  - FIFO, empty: r2r_out unchanged, underrun<=1.
  - RAMP: r2r_out<=r2r_out+1, wrapping 0xFF→0x00.
  - TRIANGLE, direction up: r2r_out+1; at 0xFE→0xFF, direction flips to down.
  - TRIANGLE, direction down: r2r_out-1; at 0x01→0x00, direction flips to up.
  - TRIANGLE period = 510 ticks; each extreme is output once.
  - Entering TRIANGLE with r2r_out=0xFF and direction up: first step is down to 0xFE, direction flips.
- FIFO write:
  - Accepted when wr_en && !load_divider && (count<DEPTH || pop this cycle).
  - Write while full with no pop: dropped, overflow<=1.
  - Write and pop in the same cycle: count unchanged; ordering preserved.
  - Write to an empty FIFO on a fire edge in FIFO mode: not forwarded that cycle; underrun sets and the entry becomes head.
- Pointers wrap modulo DEPTH. fifo_full and fifo_empty are registered from the next count.
- Flags: clr_flags clears underrun/overflow. A set event in the same cycle as clr_flags wins (flag remains 1).
- enable=0: FIFO still accepts writes; r2r_out holds.

Test Plan:
- Reset, then div=0, mode=RAMP, enable=1 → sample_tick high every cycle; r2r_out 0x01,0x02,… and wraps 0xFF→0x00 after 256 ticks.
- load_divider with data=9, mode=HOLD → sample_tick spacing exactly 10 cycles; r2r_out stays 0x00; load_divider asserted mid-count restarts the spacing from load.
- enable=0, push 0xA5,0x5A,0x33, div=3, mode=FIFO, then enable=1 → r2r_out 0xA5,0x5A,0x33 on successive ticks 4 cycles apart, then fifo_empty=1; the 4th tick sets underrun and r2r_out holds 0x33; clr_flags clears it.
- enable=0, push 17 bytes (DEPTH=16) → fifo_full=1 after the 16th, overflow=1 on the 17th; drain 16 and verify byte 17 was never output. Separately with div=0: write while full on a pop cycle → accepted, count stays 16, no overflow.
- mode=TRIANGLE from r2r_out=0x00, div=0 → values rise to 0xFF at tick 255 and fall to 0x00 at tick 510; each extreme appears once.
- Asynchronous reset mid-FIFO playback with 5 entries queued → all outputs at reset values immediately, without waiting for a clk edge; after release, mode=FIFO tick → underrun=1 (FIFO empty).
